// File: rtl/sky_xu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sky_xu_pkg : opcodes and controller FSM states shared by the ALU
//              and sky_alu_ctrl                               rev 1.0
// ------------------------------------------------------------------
package sky_xu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_SLT  = 4'h8,
    OP_SLTU = 4'h9,
    OP_MUL  = 4'hA
  } alu_op_e;

  localparam logic [3:0] OP_MAX = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_ctrl_state_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sky_alu_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sky_alu_ctrl_if : request/response handshake bundle       rev 1.0
// ------------------------------------------------------------------
interface sky_alu_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_a;
  logic [NUM_REQ*32-1:0]    req_b;
  logic [NUM_REQ*4-1:0]     req_op;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [TAG_W-1:0]         resp_tag;
  logic [31:0]              resp_result;
  logic                     resp_zero;
  logic                     resp_ovf;
  logic                     resp_illegal;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_result,
           resp_zero, resp_ovf, resp_illegal
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, resp_ready,
    output req_ready, resp_valid, resp_id, resp_tag, resp_result,
           resp_zero, resp_ovf, resp_illegal
  );
endinterface
`default_nettype wire

// File: rtl/sky_alu.sv
`default_nettype none
// ------------------------------------------------------------------
// sky_alu : 32-bit ALU, registered result/zero, combinational overflow
//                                                             rev 1.0
// ------------------------------------------------------------------
module sky_alu
  import sky_xu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        zero_flag,
  output logic        overflow
);
  logic [31:0] res_c;

  always_comb begin
    res_c    = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        res_c    = a + b;
        overflow = (a[31] == b[31]) && (res_c[31] != a[31]);
      end
      OP_SUB: begin
        res_c    = a - b;
        overflow = (a[31] != b[31]) && (res_c[31] != a[31]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLL:  res_c = a << b[4:0];
      OP_SRL:  res_c = a >> b[4:0];
      OP_SRA:  res_c = $signed(a) >>> b[4:0];
      OP_SLT:  res_c = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: res_c = {31'b0, a < b};
      OP_MUL:  res_c = a * b;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      zero_flag <= 1'b0;
    end else begin
      result    <= res_c;
      zero_flag <= (res_c == 32'd0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sky_rr_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// sky_rr_arb : combinational round-robin pick starting at ptr  rev 1.0
// ------------------------------------------------------------------
module sky_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] sel;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int idx;
    idx = 0;
    sel = '0;
    gnt = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (req[sel]) gnt = N'(1) << sel;
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/sky_alu_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// sky_alu_ctrl : round-robin shared-ALU controller; SKY_ALU_CTRL_PERF_EN
//                adds perf_ops/perf_stall counters              rev 1.0
// ------------------------------------------------------------------
module sky_alu_ctrl
  import sky_xu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic          clk,
  input  logic          reset,
  sky_alu_ctrl_if.slave bus
`ifdef SKY_ALU_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  alu_ctrl_state_t  state;
  logic [ID_W-1:0]  rr_ptr;
  logic [31:0]      a_q, b_q;
  logic [3:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [ID_W-1:0]  id_q;
  logic             ovf_q;

  logic [NUM_REQ-1:0] gnt;
  logic               any;
  logic [ID_W-1:0]    gnt_idx;
  logic [31:0]        sel_a, sel_b;
  logic [3:0]         sel_op;
  logic [TAG_W-1:0]   sel_tag;
  logic [31:0]        alu_result;
  logic               alu_zero, alu_ovf;

  sky_rr_arb #(.N(NUM_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .any (any)
  );

  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = ID_W'(i);
        sel_a   = bus.req_a[i*32 +: 32];
        sel_b   = bus.req_b[i*32 +: 32];
        sel_op  = bus.req_op[i*4 +: 4];
        sel_tag = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  sky_alu u_alu (
    .clk       (clk),
    .reset     (reset),
    .a         (a_q),
    .b         (b_q),
    .op        (op_q),
    .result    (alu_result),
    .zero_flag (alu_zero),
    .overflow  (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      id_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            op_q   <= sel_op;
            tag_q  <= sel_tag;
            id_q   <= gnt_idx;
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Overflow is combinational in the ALU, so it is caught while
          // the operands are first presented.
          ovf_q <= alu_ovf;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == ST_IDLE && !reset) ? gnt : '0;
  assign bus.resp_valid   = (state == ST_RESP) && !reset;
  assign bus.resp_id      = id_q;
  assign bus.resp_tag     = tag_q;
  assign bus.resp_result  = alu_result;
  assign bus.resp_zero    = alu_zero;
  assign bus.resp_ovf     = ovf_q;
  assign bus.resp_illegal = op_illegal(op_q);

`ifdef SKY_ALU_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (bus.resp_valid && bus.resp_ready)  perf_ops   <= perf_ops + 32'd1;
      if (bus.resp_valid && !bus.resp_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
